// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the 32 x 64-bit register file.
// Imported by the interface, the decoder and the storage top.
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int ZERO_REG = 31;

    typedef logic [DATA_W-1:0]       reg_word_t;
    typedef logic [ADDR_W-1:0]       reg_addr_t;
    typedef reg_word_t [NUM_REGS-1:0] reg_array_t;

    // Address of the hardwired-zero register (XZR), sized for address compares.
    localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);

endpackage

// File: rtl/regfile_storage64_if.sv
// Bundle of the register file write port, two read ports and the packed
// storage view. The datapath side uses 'master', the register file 'slave'.
interface regfile_storage64_if;
    import regfile_pkg::*;

    logic       RegWrite;
    reg_addr_t  WriteRegister;
    reg_word_t  WriteData;
    reg_addr_t  ReadRegister1;
    reg_addr_t  ReadRegister2;
    reg_word_t  ReadData1;
    reg_word_t  ReadData2;
    reg_array_t registers;

    modport master (
        output RegWrite,
        output WriteRegister,
        output WriteData,
        output ReadRegister1,
        output ReadRegister2,
        input  ReadData1,
        input  ReadData2,
        input  registers
    );

    modport slave (
        input  RegWrite,
        input  WriteRegister,
        input  WriteData,
        input  ReadRegister1,
        input  ReadRegister2,
        output ReadData1,
        output ReadData2,
        output registers
    );

endinterface

// File: rtl/regfile_storage64_decoder.sv
// 5:32 one-hot write-address decoder. All outputs are low when en is low.
module decoder5_32 (
    input  logic        en,
    input  logic [4:0]  in,
    output logic [31:0] out
);

    // Raise exactly one select line for the addressed register when enabled.
    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_storage64.sv
// 32 x 64-bit ARM register file: storage, write port, two combinational read
// ports and a packed view of all registers for the external read muxes.
// X31 (XZR) is hardwired to zero and ignores writes.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN -- when defined, a read of
// the register being written this cycle returns WriteData (write-through);
// the packed 'registers' bus always shows stored state only.
module regfile_storage64
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic reset,
    regfile_storage64_if.slave rf
);

    logic [NUM_REGS-1:0] decOut;
    logic [NUM_REGS-1:0] writeEn;
    reg_array_t          regBus;

    decoder5_32 u_decoder (
        .en  (rf.RegWrite),
        .in  (rf.WriteRegister),
        .out (decOut)
    );

    // Mask the zero-register select so a write to X31 never reaches storage.
    always_comb begin
        writeEn           = decOut;
        writeEn[ZERO_REG] = 1'b0;
    end

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            if (i == ZERO_REG) begin : g_zero
                assign regBus[i] = '0;
            end else begin : g_flop
                reg_word_t q;

                // Reset clears the register and takes priority over a write.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        q <= '0;
                    end else if (writeEn[i]) begin
                        q <= rf.WriteData;
                    end
                end

                assign regBus[i] = q;
            end
        end
    endgenerate

    assign rf.registers = regBus;

`ifdef REGFILE_WRITE_BYPASS_EN
    logic bypass1;
    logic bypass2;

    // Forward the in-flight write to a read port that selects the same register.
    always_comb begin
        bypass1 = rf.RegWrite && !reset && (rf.WriteRegister != ZERO_ADDR)
                  && (rf.ReadRegister1 == rf.WriteRegister);
        bypass2 = rf.RegWrite && !reset && (rf.WriteRegister != ZERO_ADDR)
                  && (rf.ReadRegister2 == rf.WriteRegister);
        rf.ReadData1 = bypass1 ? rf.WriteData : regBus[rf.ReadRegister1];
        rf.ReadData2 = bypass2 ? rf.WriteData : regBus[rf.ReadRegister2];
    end
`else
    // Read ports show stored state only; a same-cycle write appears after the edge.
    always_comb begin
        rf.ReadData1 = regBus[rf.ReadRegister1];
        rf.ReadData2 = regBus[rf.ReadRegister2];
    end
`endif

endmodule
